// File: rtl/sha_sigma_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : sha_sigma_pipe
//  Purpose  : Two-stage pipelined SHA-2 sigma engine. Each lane independently
//             computes one of Sigma0 / Sigma1 / sigma0 / sigma1 on a W-bit
//             word (W=32 -> SHA-256 constants, W=64 -> SHA-512 constants).
//             Stage 1 registers the three selected rotate/shift terms;
//             stage 2 registers their XOR. Valid/ready flow control on both
//             sides; capacity of two transfers in flight.
//  Options  : SHA_SIGMA_STATS_EN adds the stat_count port, a saturating
//             16-bit count of output handshakes.
//  Revision : 1.0 - initial release
// ============================================================================
module sha_sigma_pipe #(
    parameter int W     = 32,
    parameter int LANES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*LANES-1:0]   in_mode,
    input  logic [W*LANES-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W*LANES-1:0]   out_data
`ifdef SHA_SIGMA_STATS_EN
    ,
    output logic [15:0]          stat_count
`endif
);

    // Rotate/shift amounts, chosen once at elaboration from the word width.
    localparam int BIG_S0_A = (W == 64) ? 28 : 2;
    localparam int BIG_S0_B = (W == 64) ? 34 : 13;
    localparam int BIG_S0_C = (W == 64) ? 39 : 22;
    localparam int BIG_S1_A = (W == 64) ? 14 : 6;
    localparam int BIG_S1_B = (W == 64) ? 18 : 11;
    localparam int BIG_S1_C = (W == 64) ? 41 : 25;
    localparam int SML_S0_A = (W == 64) ? 1  : 7;
    localparam int SML_S0_B = (W == 64) ? 8  : 18;
    localparam int SML_S0_C = (W == 64) ? 7  : 3;   // logical shift
    localparam int SML_S1_A = (W == 64) ? 19 : 17;
    localparam int SML_S1_B = (W == 64) ? 61 : 19;
    localparam int SML_S1_C = (W == 64) ? 6  : 10;  // logical shift

    localparam int TW = 3 * W;  // bits of stage-1 storage per lane

    localparam logic [1:0] MODE_BIG_S0 = 2'b00;
    localparam logic [1:0] MODE_BIG_S1 = 2'b01;
    localparam logic [1:0] MODE_SML_S0 = 2'b10;
    localparam logic [1:0] MODE_SML_S1 = 2'b11;

    // Only the two SHA-2 word sizes and 1..8 lanes are meaningful.
    if (!(W == 32 || W == 64)) begin : g_bad_width
        $error("sha_sigma_pipe: W must be 32 or 64");
    end
    if (LANES < 1 || LANES > 8) begin : g_bad_lanes
        $error("sha_sigma_pipe: LANES must be in 1..8");
    end

    function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input int n);
        rotr = (x >> n) | (x << (W - n));
    endfunction

    // Pipeline state
    logic                 s1_valid_q, s1_valid_d;
    logic [TW*LANES-1:0]  s1_terms_q, s1_terms_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [W*LANES-1:0]   out_data_q, out_data_d;

    // Per-lane combinational results
    logic [TW*LANES-1:0]  w_terms;
    logic [W*LANES-1:0]   w_xor;

    logic w_s2_adv;
    logic w_in_acc;
    logic w_out_acc;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [W-1:0] w_x;
        logic [W-1:0] w_t0;
        logic [W-1:0] w_t1;
        logic [W-1:0] w_t2;

        assign w_x = in_data[W*i +: W];

        // Pick this lane's three terms from its own mode field.
        always_comb begin
            w_t0 = rotr(w_x, BIG_S0_A);
            w_t1 = rotr(w_x, BIG_S0_B);
            w_t2 = rotr(w_x, BIG_S0_C);
            case (in_mode[2*i +: 2])
                MODE_BIG_S0: begin
                    w_t0 = rotr(w_x, BIG_S0_A);
                    w_t1 = rotr(w_x, BIG_S0_B);
                    w_t2 = rotr(w_x, BIG_S0_C);
                end
                MODE_BIG_S1: begin
                    w_t0 = rotr(w_x, BIG_S1_A);
                    w_t1 = rotr(w_x, BIG_S1_B);
                    w_t2 = rotr(w_x, BIG_S1_C);
                end
                MODE_SML_S0: begin
                    w_t0 = rotr(w_x, SML_S0_A);
                    w_t1 = rotr(w_x, SML_S0_B);
                    w_t2 = w_x >> SML_S0_C;
                end
                MODE_SML_S1: begin
                    w_t0 = rotr(w_x, SML_S1_A);
                    w_t1 = rotr(w_x, SML_S1_B);
                    w_t2 = w_x >> SML_S1_C;
                end
                default: ;
            endcase
        end

        assign w_terms[TW*i +: TW] = {w_t2, w_t1, w_t0};
        assign w_xor[W*i +: W]     = s1_terms_q[TW*i +: W]
                                   ^ s1_terms_q[TW*i + W +: W]
                                   ^ s1_terms_q[TW*i + 2*W +: W];
    end

    // Stage 2 advances when it is empty or being drained; stage 1 can take
    // a new word whenever it is empty or moving on in the same cycle.
    assign w_s2_adv  = s1_valid_q && (!s2_valid_q || out_ready);
    assign in_ready  = !s1_valid_q || w_s2_adv;
    assign w_in_acc  = in_valid && in_ready;
    assign w_out_acc = s2_valid_q && out_ready;

    // Next-state for both stages; stalled stages keep their contents.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_terms_d = s1_terms_q;
        s2_valid_d = s2_valid_q;
        out_data_d = out_data_q;

        if (w_in_acc) begin
            s1_valid_d = 1'b1;
            s1_terms_d = w_terms;
        end else if (w_s2_adv) begin
            s1_valid_d = 1'b0;
        end

        if (w_s2_adv) begin
            s2_valid_d = 1'b1;
            out_data_d = w_xor;
        end else if (w_out_acc) begin
            s2_valid_d = 1'b0;
        end
    end

    // Pipeline registers with synchronous reset discarding in-flight words.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_terms_q <= '0;
            s2_valid_q <= 1'b0;
            out_data_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_terms_q <= s1_terms_d;
            s2_valid_q <= s2_valid_d;
            out_data_q <= out_data_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = out_data_q;

`ifdef SHA_SIGMA_STATS_EN
    logic [15:0] stat_count_q;

    // Saturating count of completed output handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_count_q <= '0;
        end else if (w_out_acc && (stat_count_q != 16'hFFFF)) begin
            stat_count_q <= stat_count_q + 16'd1;
        end
    end

    assign stat_count = stat_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sha_sigma_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sha_sigma_pipe
//  Purpose  : Directed self-checking bench for sha_sigma_pipe. Three
//             instances: 32-bit x4 lanes, 64-bit x1 lane, 32-bit x1 lane.
//             SHA_SIGMA_STATS_EN enables the stat_count checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sha_sigma_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // Instance A: W=32, LANES=4
    logic         a_in_valid = 1'b0;
    logic         a_in_ready;
    logic [7:0]   a_in_mode  = '0;
    logic [127:0] a_in_data  = '0;
    logic         a_out_valid;
    logic         a_out_ready = 1'b0;
    logic [127:0] a_out_data;

    // Instance B: W=64, LANES=1
    logic         b_in_valid = 1'b0;
    logic         b_in_ready;
    logic [1:0]   b_in_mode  = '0;
    logic [63:0]  b_in_data  = '0;
    logic         b_out_valid;
    logic         b_out_ready = 1'b0;
    logic [63:0]  b_out_data;

    // Instance C: W=32, LANES=1
    logic         c_in_valid = 1'b0;
    logic         c_in_ready;
    logic [1:0]   c_in_mode  = '0;
    logic [31:0]  c_in_data  = '0;
    logic         c_out_valid;
    logic         c_out_ready = 1'b0;
    logic [31:0]  c_out_data;

`ifdef SHA_SIGMA_STATS_EN
    logic [15:0]  a_stat_count;
    logic [15:0]  b_stat_count;
    logic [15:0]  c_stat_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    sha_sigma_pipe #(.W(32), .LANES(4)) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (a_in_valid),
        .in_ready   (a_in_ready),
        .in_mode    (a_in_mode),
        .in_data    (a_in_data),
        .out_valid  (a_out_valid),
        .out_ready  (a_out_ready),
        .out_data   (a_out_data)
`ifdef SHA_SIGMA_STATS_EN
        ,
        .stat_count (a_stat_count)
`endif
    );

    sha_sigma_pipe #(.W(64), .LANES(1)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .in_mode    (b_in_mode),
        .in_data    (b_in_data),
        .out_valid  (b_out_valid),
        .out_ready  (b_out_ready),
        .out_data   (b_out_data)
`ifdef SHA_SIGMA_STATS_EN
        ,
        .stat_count (b_stat_count)
`endif
    );

    sha_sigma_pipe #(.W(32), .LANES(1)) u_dut_c (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (c_in_valid),
        .in_ready   (c_in_ready),
        .in_mode    (c_in_mode),
        .in_data    (c_in_data),
        .out_valid  (c_out_valid),
        .out_ready  (c_out_ready),
        .out_data   (c_out_data)
`ifdef SHA_SIGMA_STATS_EN
        ,
        .stat_count (c_stat_count)
`endif
    );

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_tests++;
        if (a_out_valid !== 1'b0 || a_out_data !== 128'h0 || a_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_a: valid=%b data=%h ready=%b, want 0/0/1", a_out_valid, a_out_data, a_in_ready);
        end
        n_tests++;
        if (b_out_valid !== 1'b0 || b_out_data !== 64'h0 || b_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_b: valid=%b data=%h ready=%b, want 0/0/1", b_out_valid, b_out_data, b_in_ready);
        end
        n_tests++;
        if (c_out_valid !== 1'b0 || c_out_data !== 32'h0 || c_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_c: valid=%b data=%h ready=%b, want 0/0/1", c_out_valid, c_out_data, c_in_ready);
        end
    endtask

    // Sigma0 of 1 through the single-lane 32-bit engine, latency checked.
    task automatic test_single_lane();
        c_out_ready = 1'b1;
        c_in_mode   = 2'b00;
        c_in_data   = 32'h0000_0001;
        c_in_valid  = 1'b1;
        tick();                       // accept edge
        c_in_valid = 1'b0;
        c_in_data  = 32'hDEAD_BEEF;
        n_tests++;
        if (c_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early: out_valid=%b, want 0", c_out_valid);
        end
        tick();
        n_tests++;
        if (c_out_valid !== 1'b1 || c_out_data !== 32'h4008_0400) begin
            n_fail++;
            $display("FAIL single_result: valid=%b data=%h, want 1/40080400", c_out_valid, c_out_data);
        end
        tick();
        n_tests++;
        if (c_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_consume: out_valid=%b, want 0", c_out_valid);
        end
    endtask

    // Four lanes with four different modes, two data patterns.
    task automatic test_multi_lane();
        logic [127:0] data_v [2];
        logic [127:0] exp_v  [2];
        data_v[0] = {32'h0000_0400, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001};
        exp_v[0]  = {32'h0280_0001, 32'h0200_4000, 32'h0420_0080, 32'h4008_0400};
        data_v[1] = {4{32'hFFFF_FFFF}};
        exp_v[1]  = {32'h003F_FFFF, 32'h1FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        a_out_ready = 1'b1;
        a_in_mode   = 8'b11_10_01_00;
        for (int k = 0; k < 2; k++) begin
            a_in_data  = data_v[k];
            a_in_valid = 1'b1;
            tick();
            a_in_valid = 1'b0;
            tick();
            n_tests++;
            if (a_out_valid !== 1'b1 || a_out_data !== exp_v[k]) begin
                n_fail++;
                $display("FAIL multi_lane[%0d]: valid=%b data=%h, want 1/%h", k, a_out_valid, a_out_data, exp_v[k]);
            end
            tick();
        end
    endtask

    // 64-bit words streamed on consecutive cycles with out_ready held high.
    task automatic test_back_to_back();
        logic [1:0]  mode_v [4];
        logic [63:0] data_v [4];
        logic [63:0] exp_v  [4];
        mode_v[0] = 2'b10; data_v[0] = 64'h0000_0000_0000_0080; exp_v[0] = 64'h8000_0000_0000_0041;
        mode_v[1] = 2'b00; data_v[1] = 64'h0000_0000_0000_0001; exp_v[1] = 64'h0000_0010_4200_0000;
        mode_v[2] = 2'b01; data_v[2] = 64'h0000_0000_0000_0001; exp_v[2] = 64'h0004_4000_0080_0000;
        mode_v[3] = 2'b11; data_v[3] = 64'hFFFF_FFFF_FFFF_FFFF; exp_v[3] = 64'h03FF_FFFF_FFFF_FFFF;
        b_out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                b_in_valid = 1'b1;
                b_in_mode  = mode_v[k];
                b_in_data  = data_v[k];
                n_tests++;
                if (b_in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_ready[%0d]: in_ready=%b, want 1", k, b_in_ready);
                end
            end else begin
                b_in_valid = 1'b0;
            end
            tick();
            if (k >= 1 && k <= 4) begin
                n_tests++;
                if (b_out_valid !== 1'b1 || b_out_data !== exp_v[k-1]) begin
                    n_fail++;
                    $display("FAIL b2b_out[%0d]: valid=%b data=%h, want 1/%h", k-1, b_out_valid, b_out_data, exp_v[k-1]);
                end
            end else begin
                n_tests++;
                if (b_out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_idle[%0d]: out_valid=%b, want 0", k, b_out_valid);
                end
            end
        end
    endtask

    // Stall the output, fill both stages, then release and drain in order.
    task automatic test_backpressure();
        logic [127:0] exp_v [3];
        exp_v[0] = {4{32'h4008_0400}};
        exp_v[1] = {4{32'h0420_0080}};
        exp_v[2] = {4{32'h0200_4000}};
        a_out_ready = 1'b0;
        a_in_data   = {4{32'h0000_0001}};
        a_in_valid  = 1'b1;
        a_in_mode   = {4{2'b00}};
        tick();
        a_in_mode = {4{2'b01}};
        n_tests++;
        if (a_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_second_ready: in_ready=%b, want 1", a_in_ready);
        end
        tick();
        a_in_mode = {4{2'b10}};
        n_tests++;
        if (a_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full_ready: in_ready=%b, want 0", a_in_ready);
        end
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (a_out_valid !== 1'b1 || a_out_data !== exp_v[0] || a_in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: valid=%b data=%h ready=%b, want 1/%h/0", k, a_out_valid, a_out_data, a_in_ready, exp_v[0]);
            end
            tick();
        end
        a_out_ready = 1'b1;
        #1;
        n_tests++;
        if (a_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_ready: in_ready=%b, want 1", a_in_ready);
        end
        tick();                       // consume w0, w1 -> S2, accept w2
        a_in_valid = 1'b0;
        for (int k = 1; k < 3; k++) begin
            n_tests++;
            if (a_out_valid !== 1'b1 || a_out_data !== exp_v[k]) begin
                n_fail++;
                $display("FAIL bp_drain[%0d]: valid=%b data=%h, want 1/%h", k, a_out_valid, a_out_data, exp_v[k]);
            end
            tick();
        end
        n_tests++;
        if (a_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_empty: out_valid=%b, want 0", a_out_valid);
        end
    endtask

    // Reset with two words in flight must drop both.
    task automatic test_reset_midflight();
        a_out_ready = 1'b0;
        a_in_mode   = 8'b11_10_01_00;
        a_in_data   = {4{32'h1234_5678}};
        a_in_valid  = 1'b1;
        tick();
        tick();
        a_in_valid = 1'b0;
        n_tests++;
        if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_full: valid=%b ready=%b, want 1/0", a_out_valid, a_in_ready);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if (a_out_valid !== 1'b0 || a_out_data !== 128'h0 || a_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset: valid=%b data=%h ready=%b, want 0/0/1", a_out_valid, a_out_data, a_in_ready);
        end
`ifdef SHA_SIGMA_STATS_EN
        n_tests++;
        if (a_stat_count !== 16'h0) begin
            n_fail++;
            $display("FAIL mid_stat: stat_count=%h, want 0000", a_stat_count);
        end
`endif
        a_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_tests++;
            if (a_out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_stale[%0d]: out_valid=%b, want 0", k, a_out_valid);
            end
        end
    endtask

`ifdef SHA_SIGMA_STATS_EN
    // Count a few handshakes exactly, then run past saturation.
    task automatic test_stats();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        c_out_ready = 1'b1;
        c_in_mode   = 2'b00;
        c_in_data   = 32'h1;
        c_in_valid  = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        c_in_valid = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        n_tests++;
        if (c_stat_count !== 16'd5) begin
            n_fail++;
            $display("FAIL stat_small: stat_count=%0d, want 5", c_stat_count);
        end
        c_in_valid = 1'b1;
        for (int k = 0; k < 70000; k++) tick();
        c_in_valid = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        n_tests++;
        if (c_stat_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL stat_saturate: stat_count=%h, want ffff", c_stat_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_lane();
        test_multi_lane();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
`ifdef SHA_SIGMA_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
